// File: rtl/noc_pkg.sv
// Shared NoC router definitions: flit id encodings, field positions and the
// input-port framing FSM state type.
package noc_pkg;

  localparam int unsigned FlitDataWidth = 32;
  localparam int unsigned IdWidth       = 3;
  localparam int unsigned LenLsb        = 0;
  localparam int unsigned LenWidth      = 12;

  localparam logic [IdWidth-1:0] FlitNone   = 3'b000;
  localparam logic [IdWidth-1:0] FlitHeader = 3'b001;
  localparam logic [IdWidth-1:0] FlitBody   = 3'b010;
  localparam logic [IdWidth-1:0] FlitTail   = 3'b100;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StXfer
  } ipb_state_e;

endpackage

// File: rtl/input_port_buffer_if.sv
// Link, crossbar and arbiter-facing signals of one router input port.
interface input_port_buffer_if #(
  parameter int unsigned DATA_WIDTH = noc_pkg::FlitDataWidth
);
  logic [DATA_WIDTH-1:0]        in_flit;
  logic                         in_valid;
  logic                         in_ready;
  logic                         grant;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        out_flit;
  logic                         out_valid;
  logic [noc_pkg::IdWidth-1:0]  flit_id;
  logic [noc_pkg::LenWidth-1:0] length;
  logic                         req;
  logic                         err;

  // Upstream link plus arbiter/crossbar side.
  modport master (
    output in_flit, in_valid, grant, out_ready,
    input  in_ready, out_flit, out_valid, flit_id, length, req, err
  );

  // The input port buffer itself.
  modport slave (
    input  in_flit, in_valid, grant, out_ready,
    output in_ready, out_flit, out_valid, flit_id, length, req, err
  );
endinterface

// File: rtl/flit_fifo.sv
// Circular flit FIFO with registered head; no write-to-read bypass.
module flit_fifo
  import noc_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = FlitDataWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] CountFull = (PtrW + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]         count_q;
  logic                  do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CountFull);
  assign empty = (count_q == '0);

endmodule

// File: rtl/input_port_buffer.sv
// Router input stage: buffers flits, frames packets and requests/forwards
// them through the port arbiter and crossbar.
module input_port_buffer
  import noc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FlitDataWidth,
  parameter int unsigned DEPTH      = 8
) (
  input logic                 clk,
  input logic                 rst,
  input_port_buffer_if.slave  bus
);

  logic [DATA_WIDTH-1:0] head;
  logic [IdWidth-1:0]    head_id;
  logic                  full, empty, push, pop;
  logic                  fwd_valid, drop, err;
  ipb_state_e            state_q, state_d;
  logic [LenWidth-1:0]   length_q, length_d;

  assign push    = bus.in_valid && !full;
  assign head_id = head[DATA_WIDTH-1 -: IdWidth];
  assign pop     = drop || (fwd_valid && bus.out_ready);

  flit_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (bus.in_flit),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      length_q <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    fwd_valid = 1'b0;
    drop      = 1'b0;
    err       = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          if (head_id == FlitHeader) begin
            state_d  = StReq;
            length_d = head[LenLsb +: LenWidth];
          end else begin
            drop = 1'b1;
            err  = 1'b1;
          end
        end
      end
      StReq: begin
        // The head is always the registered header here.
        fwd_valid = bus.grant && !empty;
        if (fwd_valid && bus.out_ready) state_d = StXfer;
      end
      StXfer: begin
        fwd_valid = bus.grant && !empty;
        if (fwd_valid && bus.out_ready) begin
          if (head_id == FlitTail) begin
            state_d = StIdle;
          end else if (head_id != FlitBody) begin
            // Stray header or bad id inside a packet: flag once, forward as data.
            err = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.in_ready  = !full;
  assign bus.out_flit  = head;
  assign bus.out_valid = fwd_valid;
  assign bus.flit_id   = empty ? FlitNone : head_id;
  assign bus.length    = length_q;
  assign bus.req       = (state_q != StIdle);
  assign bus.err       = err;

endmodule

// File: tb/tb_input_port_buffer.sv
// Randomized self-checking bench for input_port_buffer with a packet-level
// reference model of the forwarded flit stream and framing errors.
module tb_input_port_buffer;
  import noc_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  input_port_buffer_if #(.DATA_WIDTH(DW)) bus ();

  input_port_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp   = 0;
  int n_fail  = 0;
  int exp_err = 0;
  int got_err = 0;
  int pops    = 0;
  logic [DW-1:0] exp_q[$];
  bit in_pkt = 1'b0;
  logic [DW-1:0] mon_exp;

  function automatic logic [DW-1:0] mk(logic [2:0] id, logic [11:0] len);
    logic [DW-1:0] f;
    f = DW'($urandom);
    f[DW-1 -: 3] = id;
    if (id == FlitHeader) f[11:0] = len;
    return f;
  endfunction

  function automatic logic [2:0] bad_id();
    logic [2:0] ids [7];
    ids = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    return ids[$urandom_range(0, 6)];
  endfunction

  // Packet-level model on the accepted input stream: outside a packet only a
  // header is kept; inside, everything is forwarded until a tail.
  function automatic void model_push(logic [DW-1:0] f);
    logic [2:0] id;
    id = f[DW-1 -: 3];
    if (!in_pkt) begin
      if (id == FlitHeader) begin
        exp_q.push_back(f);
        in_pkt = 1'b1;
      end else begin
        exp_err++;
      end
    end else begin
      exp_q.push_back(f);
      if (id == FlitTail) in_pkt = 1'b0;
      else if (id != FlitBody) exp_err++;
    end
  endfunction

  always @(negedge clk) begin
    #3;
    if (rst) begin
      if (bus.in_valid && bus.in_ready) model_push(bus.in_flit);
      if (bus.err) got_err++;
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_data: popped %h, required no pop", bus.out_flit);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.out_flit !== mon_exp) begin
            n_fail++;
            $display("FAIL pop_data: got %h, required %h", bus.out_flit, mon_exp);
          end
        end
      end
    end
  end

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 80 && !ok; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.grant     = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      if (exp_q.size() == 0 && !bus.req && bus.flit_id == FlitNone) ok = 1'b1;
    end
    bus.grant = 1'b0;
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); end
    n_cmp++; if (bus.req !== 1'b0) begin n_fail++;
      $display("FAIL reset_req: got %b, required 0", bus.req); end
    n_cmp++; if (bus.flit_id !== 3'b000) begin n_fail++;
      $display("FAIL reset_flit_id: got %b, required 000", bus.flit_id); end
    n_cmp++; if (bus.length !== 12'd0) begin n_fail++;
      $display("FAIL reset_length: got %0d, required 0", bus.length); end
    n_cmp++; if (bus.err !== 1'b0) begin n_fail++;
      $display("FAIL reset_err: got %b, required 0", bus.err); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int p0;
    p0 = pops;
    bus.grant = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_flit = mk(FlitHeader, 12'd3);
    @(negedge clk); bus.in_flit = mk(FlitBody, 12'd0); #1;
    n_cmp++; if (bus.flit_id !== FlitHeader) begin n_fail++;
      $display("FAIL basic_head_id: got %b, required 001", bus.flit_id); end
    n_cmp++; if (bus.req !== 1'b0) begin n_fail++;
      $display("FAIL basic_req_early: got %b, required 0", bus.req); end
    @(negedge clk); bus.in_flit = mk(FlitTail, 12'd0); #1;
    n_cmp++; if (bus.req !== 1'b1) begin n_fail++;
      $display("FAIL basic_req_rise: got %b, required 1", bus.req); end
    n_cmp++; if (bus.length !== 12'd3) begin n_fail++;
      $display("FAIL basic_length: got %0d, required 3", bus.length); end
    @(negedge clk); bus.in_valid = 1'b0;
    @(negedge clk); bus.grant = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++;
        $display("FAIL basic_stream_%0d: out_valid %b, required 1", i, bus.out_valid); end
    end
    @(negedge clk); #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_fail++;
      $display("FAIL basic_req_fall: got %b, required 0", bus.req); end
    n_cmp++; if (pops - p0 !== 3) begin n_fail++;
      $display("FAIL basic_pops: got %0d, required 3", pops - p0); end
    bus.grant = 1'b0;
  endtask

  task automatic test_fill();
    bit ok;
    bus.grant = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      if (i == 0)      bus.in_flit = mk(FlitHeader, 12'($urandom_range(1, 4095)));
      else if (i == 7) bus.in_flit = mk(FlitTail, 12'd0);
      else             bus.in_flit = mk(FlitBody, 12'd0);
      #1;
      if (i == 7) begin
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++;
          $display("FAIL fill_ready_at_7: got %b, required 1", bus.in_ready); end
      end
    end
    @(negedge clk); bus.in_flit = mk(FlitBody, 12'd0); #1;
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++;
      $display("FAIL fill_full: in_ready %b, required 0", bus.in_ready); end
    @(negedge clk); bus.grant = 1'b1; #1;
    n_cmp++; if ({bus.out_valid, bus.in_ready} !== 2'b10) begin n_fail++;
      $display("FAIL fill_pop_cycle: out_valid,in_ready %b, required 10",
               {bus.out_valid, bus.in_ready}); end
    @(negedge clk); bus.grant = 1'b0; bus.in_valid = 1'b0; #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL fill_room: in_ready %b, required 1", bus.in_ready); end
    drain(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++;
      $display("FAIL fill_drain: drained %b, required 1", ok); end
  endtask

  task automatic test_grant_withdraw();
    int p0, p_mid;
    p0 = pops;
    bus.grant = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_flit  = (i == 0) ? mk(FlitHeader, 12'd5) :
                     (i == 4) ? mk(FlitTail, 12'd0) : mk(FlitBody, 12'd0);
    end
    @(negedge clk); bus.in_valid = 1'b0; bus.grant = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.grant = 1'b0;
    p_mid = pops;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({bus.req, bus.out_valid, dut.state_q == StXfer} !== 3'b101) begin n_fail++;
        $display("FAIL gw_hold_%0d: req,out_valid,xfer %b, required 101", i,
                 {bus.req, bus.out_valid, dut.state_q == StXfer}); end
      @(negedge clk);
    end
    n_cmp++; if (pops !== p_mid) begin n_fail++;
      $display("FAIL gw_no_pops: got %0d pops, required 0", pops - p_mid); end
    bus.grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++;
        $display("FAIL gw_resume_%0d: out_valid %b, required 1", i, bus.out_valid); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (bus.req !== 1'b0) begin n_fail++;
      $display("FAIL gw_req_fall: got %b, required 0", bus.req); end
    n_cmp++; if (pops - p0 !== 5) begin n_fail++;
      $display("FAIL gw_pops: got %0d, required 5", pops - p0); end
    bus.grant = 1'b0;
  endtask

  task automatic test_idle_error();
    int e0;
    bit ok;
    logic [11:0] len;
    e0 = got_err;
    len = 12'($urandom_range(1, 4095));
    bus.grant = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_flit = mk(bad_id(), 12'd0);
    @(negedge clk); bus.in_valid = 1'b0; #1;
    n_cmp++; if ({bus.err, bus.req} !== 2'b10) begin n_fail++;
      $display("FAIL ierr_pulse: err,req %b, required 10", {bus.err, bus.req}); end
    @(negedge clk); #1;
    n_cmp++; if ({bus.err, bus.flit_id} !== 4'b0000) begin n_fail++;
      $display("FAIL ierr_dropped: err,flit_id %b, required 0000", {bus.err, bus.flit_id}); end
    @(negedge clk); bus.in_valid = 1'b1; bus.in_flit = mk(FlitHeader, len);
    @(negedge clk); bus.in_flit = mk(FlitTail, 12'd0);
    @(negedge clk); bus.in_valid = 1'b0; #1;
    n_cmp++; if ({bus.req, bus.length} !== {1'b1, len}) begin n_fail++;
      $display("FAIL ierr_next_hdr: req,length %b/%0d, required 1/%0d", bus.req, bus.length, len);
    end
    drain(ok);
    n_cmp++; if ({ok, 32'(got_err - e0)} !== {1'b1, 32'd1}) begin n_fail++;
      $display("FAIL ierr_count: drained %b errs %0d, required 1 and 1", ok, got_err - e0); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] src[$];
    bit req_hist[$];
    logic [11:0] len_a, len_b, len_seen;
    int nb, first_hi, last_hi, gaps;
    len_a = 12'($urandom_range(1, 4095));
    len_b = 12'($urandom_range(1, 4095));
    nb = $urandom_range(0, 3);
    src.push_back(mk(FlitHeader, len_a));
    for (int i = 0; i < nb; i++) src.push_back(mk(FlitBody, 12'd0));
    src.push_back(mk(FlitTail, 12'd0));
    src.push_back(mk(FlitHeader, len_b));
    src.push_back(mk(FlitTail, 12'd0));
    len_seen = '0;
    bus.grant = 1'b1; bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (src.size() > 0 && bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_flit  = src.pop_front();
      end
      #1;
      if (bus.req && req_hist.size() > 0 && !req_hist[req_hist.size()-1] && len_seen == '0)
        len_seen = bus.length;
      req_hist.push_back(bus.req);
    end
    first_hi = -1; last_hi = -1; gaps = 0;
    foreach (req_hist[i]) if (req_hist[i]) begin
      if (first_hi < 0) first_hi = i;
      last_hi = i;
    end
    for (int i = first_hi + 1; i < last_hi; i++) if (!req_hist[i]) gaps++;
    n_cmp++; if (gaps !== 1 || first_hi < 0) begin n_fail++;
      $display("FAIL b2b_gap: req low %0d cycles between packets, required 1", gaps); end
    n_cmp++; if (len_seen !== len_a) begin n_fail++;
      $display("FAIL b2b_len_a: got %0d, required %0d", len_seen, len_a); end
    n_cmp++; if (bus.length !== len_b) begin n_fail++;
      $display("FAIL b2b_len_b: got %0d, required %0d", bus.length, len_b); end
    n_cmp++; if (exp_q.size() !== 0 || bus.req !== 1'b0) begin n_fail++;
      $display("FAIL b2b_done: %0d flits left, req %b, required 0 and 0", exp_q.size(), bus.req);
    end
    bus.grant = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [11:0] len;
    int p0;
    bit ok;
    bus.grant = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_flit  = (i == 0) ? mk(FlitHeader, 12'($urandom_range(1, 4095))) : mk(FlitBody, 12'd0);
    end
    @(negedge clk); bus.in_valid = 1'b0; bus.grant = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2; rst = 1'b0; #1;
    exp_q.delete();
    in_pkt = 1'b0;
    n_cmp++;
    if ({bus.req, bus.out_valid, bus.in_ready, bus.flit_id, bus.length, bus.err} !==
        {1'b0, 1'b0, 1'b1, 3'b000, 12'd0, 1'b0}) begin n_fail++;
      $display("FAIL rm_async: req,out_valid,in_ready,flit_id,length,err %b %b %b %b %0d %b, required 0 0 1 000 0 0",
               bus.req, bus.out_valid, bus.in_ready, bus.flit_id, bus.length, bus.err);
    end
    @(negedge clk); rst = 1'b1; #1;
    n_cmp++; if ({dut.state_q == StIdle, bus.flit_id} !== 4'b1000) begin n_fail++;
      $display("FAIL rm_after: idle,flit_id %b, required 1000", {dut.state_q == StIdle, bus.flit_id});
    end
    p0 = pops;
    len = 12'($urandom_range(1, 4095));
    bus.grant = 1'b0;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_flit = mk(FlitHeader, len);
    @(negedge clk); bus.in_flit = mk(FlitTail, 12'd0);
    drain(ok);
    n_cmp++; if ({ok, bus.length, 32'(pops - p0)} !== {1'b1, len, 32'd2}) begin n_fail++;
      $display("FAIL rm_restart: drained %b length %0d pops %0d, required 1 %0d 2",
               ok, bus.length, pops - p0, len);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] src[$];
    int e0, x0, nb;
    bit ok;
    e0 = got_err; x0 = exp_err;
    for (int p = 0; p < 8; p++) begin
      if ($urandom_range(0, 2) == 0) src.push_back(mk(bad_id(), 12'd0));
      src.push_back(mk(FlitHeader, 12'($urandom_range(1, 4095))));
      nb = $urandom_range(0, 5);
      for (int i = 0; i < nb; i++) begin
        if ($urandom_range(0, 4) == 0)
          src.push_back(mk(($urandom_range(0, 1) == 0) ? FlitHeader : 3'b011, 12'd5));
        else
          src.push_back(mk(FlitBody, 12'd0));
      end
      src.push_back(mk(FlitTail, 12'd0));
    end
    for (int c = 0; c < 1500 && src.size() > 0; c++) begin
      @(negedge clk);
      bus.grant     = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 4) != 0);
      bus.in_valid  = 1'b0;
      if ($urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_flit  = src[0];
      end
      #1;
      if (bus.in_valid && bus.in_ready) void'(src.pop_front());
    end
    n_cmp++; if (src.size() !== 0) begin n_fail++;
      $display("FAIL rnd_accept: %0d flits never accepted, required 0", src.size()); end
    drain(ok);
    n_cmp++; if (ok !== 1'b1) begin n_fail++;
      $display("FAIL rnd_drain: drained %b, required 1", ok); end
    n_cmp++; if (got_err - e0 !== exp_err - x0) begin n_fail++;
      $display("FAIL rnd_err: got %0d err pulses, required %0d", got_err - e0, exp_err - x0); end
  endtask

  initial begin
    bus.in_flit   = '0;
    bus.in_valid  = 1'b0;
    bus.grant     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_grant_withdraw();
    test_idle_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
